// File: rtl/snoop_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_arbiter_pkg
// Description : Shared definitions for the snooping bus arbiter: FSM state
//               encoding, address/data widths and default memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
package snoop_bus_arbiter_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int MEM_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage : snoop_bus_arbiter_pkg
`default_nettype wire

// File: rtl/snoop_bus_arbiter_bus_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem
// Description : 256x8 shared memory behind the arbiter. Synchronous write,
//               combinational read. Contents are deliberately not reset.
// Ports       : clk     - clock
//               i_we    - write enable (sampled on rising edge)
//               i_waddr - write address
//               i_wdata - write data
//               i_raddr - read address
//               o_rdata - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem
    import snoop_bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : bus_mem
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_arbiter
// Description : Two-requester round-robin bus arbiter in front of a shared
//               memory. A granted transaction is latched, held for
//               MEM_LATENCY cycles, then completed with a one-cycle finish
//               pulse to the owner and, for writes, a one-cycle snoop
//               invalidate to the other cache.
// Ports       : CC_clk / rst (async, active low)
//               i_bus_access0/1, i_write_opn0/1, i_read_select0/1,
//               i_write_select0/1, i_write_data0/1 - requester inputs
//               o_out_data_Mem - read data (held outside DONE)
//               o_finish0/1    - completion pulse to owner
//               o_flag_snoop0/1, o_snoop_address - invalidate to non-owner
//               o_bus_grant    - one-hot owner, 00 when idle
//               o_bus_busy     - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
)(
    input  logic              CC_clk,
    input  logic              rst,
    input  logic              i_bus_access0,
    input  logic              i_bus_access1,
    input  logic              i_write_opn0,
    input  logic              i_write_opn1,
    input  logic [ADDR_W-1:0] i_read_select0,
    input  logic [ADDR_W-1:0] i_read_select1,
    input  logic [ADDR_W-1:0] i_write_select0,
    input  logic [ADDR_W-1:0] i_write_select1,
    input  logic [DATA_W-1:0] i_write_data0,
    input  logic [DATA_W-1:0] i_write_data1,
    output logic [DATA_W-1:0] o_out_data_Mem,
    output logic              o_finish0,
    output logic              o_finish1,
    output logic              o_flag_snoop0,
    output logic              o_flag_snoop1,
    output logic [ADDR_W-1:0] o_snoop_address,
    output logic [1:0]        o_bus_grant,
    output logic              o_bus_busy
);

    localparam logic [3:0] c_LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_latch;
    logic              w_go_done;
    logic              w_pick1;

    logic              r_owner;       // 1 = requester 1 owns the bus
    logic              r_last_owner;  // owner of the most recent grant
    logic [1:0]        r_grant;
    logic              r_wr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_finish0;
    logic              r_finish1;
    logic              r_snoop0;
    logic              r_snoop1;
    logic [ADDR_W-1:0] r_snoop_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_mem_we;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CC_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_go_done    = 1'b0;
        // On a tie requester 1 only wins if requester 0 was the last owner.
        w_pick1      = i_bus_access1 & (~i_bus_access0 | ~r_last_owner);
        case (r_state)
            ST_IDLE: begin
                if (i_bus_access0 || i_bus_access1) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_go_done    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CC_clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;   // makes requester 0 win the first tie
            r_grant      <= 2'b00;
            r_wr         <= 1'b0;
            r_raddr      <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_cnt        <= 4'd0;
            r_out_data   <= '0;
            r_finish0    <= 1'b0;
            r_finish1    <= 1'b0;
            r_snoop0     <= 1'b0;
            r_snoop1     <= 1'b0;
            r_snoop_addr <= '0;
        end else begin
            // Completion and snoop strobes are single-cycle by construction.
            r_finish0 <= 1'b0;
            r_finish1 <= 1'b0;
            r_snoop0  <= 1'b0;
            r_snoop1  <= 1'b0;

            if (w_latch) begin
                r_owner      <= w_pick1;
                r_last_owner <= w_pick1;
                r_grant      <= w_pick1 ? 2'b10 : 2'b01;
                r_wr         <= w_pick1 ? i_write_opn1    : i_write_opn0;
                r_raddr      <= w_pick1 ? i_read_select1  : i_read_select0;
                r_waddr      <= w_pick1 ? i_write_select1 : i_write_select0;
                r_wdata      <= w_pick1 ? i_write_data1   : i_write_data0;
                r_cnt        <= 4'd0;
            end else if (w_go_done) begin
                r_cnt     <= 4'd0;
                r_finish0 <= ~r_owner;
                r_finish1 <= r_owner;
                if (r_wr) begin
                    r_snoop0     <= r_owner;
                    r_snoop1     <= ~r_owner;
                    r_snoop_addr <= r_waddr;
                end else begin
                    r_out_data   <= w_rdata;
                end
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (r_state == ST_DONE) begin
                r_grant <= 2'b00;
            end
        end
    end

    // A write commits on the same edge that moves ACCESS into DONE.
    assign w_mem_we = w_go_done & r_wr;

    bus_mem u_bus_mem (
        .clk     (CC_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_raddr (r_raddr),
        .o_rdata (w_rdata)
    );

    assign o_out_data_Mem  = r_out_data;
    assign o_finish0       = r_finish0;
    assign o_finish1       = r_finish1;
    assign o_flag_snoop0   = r_snoop0;
    assign o_flag_snoop1   = r_snoop1;
    assign o_snoop_address = r_snoop_addr;
    assign o_bus_grant     = r_grant;
    assign o_bus_busy      = (r_state != ST_IDLE);

endmodule : snoop_bus_arbiter
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus_arbiter
// Description : Self-checking bench for snoop_bus_arbiter. A table of
//               request patterns with hand-derived expectations feeds a
//               scoreboard queue; a negedge monitor pops and compares on
//               every finish pulse. Hand sequences cover reset mid-access,
//               input changes after latching and a continuously held request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

    localparam int ML = 2;

    logic       CC_clk;
    logic       rst;
    logic       ba0, ba1, wr0, wr1;
    logic [7:0] rs0, rs1, ws0, ws1, wd0, wd1;
    logic [7:0] out_data, snaddr;
    logic       fin0, fin1, sn0, sn1, busy;
    logic [1:0] grant;

    snoop_bus_arbiter #(.MEM_LATENCY(ML)) dut (
        .CC_clk          (CC_clk),
        .rst             (rst),
        .i_bus_access0   (ba0),
        .i_bus_access1   (ba1),
        .i_write_opn0    (wr0),
        .i_write_opn1    (wr1),
        .i_read_select0  (rs0),
        .i_read_select1  (rs1),
        .i_write_select0 (ws0),
        .i_write_select1 (ws1),
        .i_write_data0   (wd0),
        .i_write_data1   (wd1),
        .o_out_data_Mem  (out_data),
        .o_finish0       (fin0),
        .o_finish1       (fin1),
        .o_flag_snoop0   (sn0),
        .o_flag_snoop1   (sn1),
        .o_snoop_address (snaddr),
        .o_bus_grant     (grant),
        .o_bus_busy      (busy)
    );

    initial CC_clk = 1'b0;
    always #5 CC_clk = ~CC_clk;

    // One request pattern: who requests, what each does, who must win first,
    // and the data each reader must see.
    typedef struct {
        bit         r0, r1;
        bit         w0, w1;
        logic [7:0] a0, d0, a1, d1;
        bit         first;
        logic [7:0] rd0, rd1;
    } vec_t;

    // Scoreboard entry: owner, write flag, snoop address (write) or data (read)
    typedef struct {
        bit         owner;
        bit         wr;
        logic [7:0] val;
    } sb_t;

    sb_t        q[$];
    vec_t       vecs[6];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] tb_last_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic sb_t mk_sb(input vec_t v, input bit k);
        sb_t e;
        e.owner = k;
        e.wr    = k ? v.w1 : v.w0;
        if (k) e.val = v.w1 ? v.a1 : v.rd1;
        else   e.val = v.w0 ? v.a0 : v.rd0;
        return e;
    endfunction

    // ------------------------------------------------------------ monitor
    always @(negedge CC_clk) begin
        sb_t        e;
        logic [1:0] exp_oh;
        if (rst) begin
            chk("grant_onehot", 32'($countones(grant) <= 1), 1);
            chk("busy_vs_grant", busy, grant != 2'b00);
            if (fin0 || fin1) begin
                if (q.size() == 0) begin
                    chk("unexpected_finish", {fin1, fin0}, 0);
                end else begin
                    e      = q.pop_front();
                    exp_oh = e.owner ? 2'b10 : 2'b01;
                    chk("finish_owner", {fin1, fin0}, exp_oh);
                    chk("grant_owner", grant, exp_oh);
                    if (e.wr) begin
                        chk("snoop_flags", {sn1, sn0}, e.owner ? 2'b01 : 2'b10);
                        chk("snoop_addr", snaddr, e.val);
                        chk("out_data_hold", out_data, tb_last_rd);
                    end else begin
                        chk("snoop_on_read", {sn1, sn0}, 0);
                        chk("read_data", out_data, e.val);
                        tb_last_rd = e.val;
                    end
                end
            end else begin
                chk("snoop_quiet", {sn1, sn0}, 0);
                chk("out_data_hold", out_data, tb_last_rd);
            end
        end
    end

    // ------------------------------------------------------------- driver
    task automatic run_vec(input vec_t v, input bit scramble, output int fe0, output int fe1);
        int edges;
        bit p0, p1;
        @(negedge CC_clk);
        wr0 = v.w0; ws0 = v.w0 ? v.a0 : ~v.a0; rs0 = v.w0 ? ~v.a0 : v.a0; wd0 = v.d0;
        wr1 = v.w1; ws1 = v.w1 ? v.a1 : ~v.a1; rs1 = v.w1 ? ~v.a1 : v.a1; wd1 = v.d1;
        ba0 = v.r0; ba1 = v.r1;
        if (v.r0 && v.r1) begin
            q.push_back(mk_sb(v, v.first));
            q.push_back(mk_sb(v, !v.first));
        end else if (v.r0) begin
            q.push_back(mk_sb(v, 1'b0));
        end else if (v.r1) begin
            q.push_back(mk_sb(v, 1'b1));
        end
        fe0 = 0; fe1 = 0; p0 = v.r0; p1 = v.r1; edges = 0;
        while ((p0 || p1) && edges < 60) begin
            @(posedge CC_clk);
            edges++;
            if (scramble && edges == 1) begin
                #1;
                wd0 = 8'hFF; wd1 = 8'hFF; ws0 = ~ws0; ws1 = ~ws1;
            end
            @(negedge CC_clk);
            if (p0 && fin0) begin p0 = 0; ba0 = 0; fe0 = edges; end
            if (p1 && fin1) begin p1 = 0; ba1 = 0; fe1 = edges; end
        end
        if (p0 || p1) begin
            chk("txn_timeout", 1, 0);
            ba0 = 0; ba1 = 0;
        end
    endtask

    initial begin
        int   fe0, fe1, ffirst, fsecond, nfin, cyc;
        vec_t v;

        //        r0 r1 w0 w1 a0     d0     a1     d1    first rd0    rd1
        vecs[0] = '{1, 1, 1, 0, 8'h3C, 8'hA5, 8'h3C, 8'h00, 0, 8'h00, 8'hA5};
        vecs[1] = '{1, 1, 0, 1, 8'h3C, 8'h00, 8'h20, 8'h77, 0, 8'hA5, 8'h00};
        vecs[2] = '{1, 0, 1, 0, 8'h21, 8'h5A, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[3] = '{1, 1, 1, 0, 8'h22, 8'h33, 8'h21, 8'h00, 1, 8'h00, 8'h5A};
        vecs[4] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h22, 8'h00, 1, 8'h00, 8'h33};
        vecs[5] = '{1, 1, 0, 0, 8'h20, 8'h00, 8'h22, 8'h00, 0, 8'h77, 8'h33};

        rst = 1'b0;
        ba0 = 0; ba1 = 0; wr0 = 0; wr1 = 0;
        rs0 = 0; rs1 = 0; ws0 = 0; ws1 = 0; wd0 = 0; wd1 = 0;
        repeat (3) @(negedge CC_clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_finish", {fin1, fin0}, 0);
        chk("rst_snoop", {sn1, sn0}, 0);
        chk("rst_snaddr", snaddr, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Table-driven patterns with latency and back-to-back gap checks
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 1'b0, fe0, fe1);
            ffirst = vecs[i].first ? fe1 : fe0;
            chk("latency_first", ffirst, ML + 1);
            if (vecs[i].r0 && vecs[i].r1) begin
                fsecond = vecs[i].first ? fe0 : fe1;
                chk("finish_gap", fsecond - ffirst, ML + 2);
            end
        end

        // Reset in the middle of a write of 0x11 to 0x20
        @(negedge CC_clk);
        wr0 = 1; ws0 = 8'h20; rs0 = 8'hDF; wd0 = 8'h11; ba0 = 1;
        @(posedge CC_clk);
        @(negedge CC_clk);
        chk("mid_busy", busy, 1);
        chk("mid_grant", grant, 2'b01);
        rst = 1'b0;
        tb_last_rd = 8'h00;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_finish", {fin1, fin0}, 0);
        chk("arst_snoop", {sn1, sn0}, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_snaddr", snaddr, 0);
        ba0 = 0;
        @(negedge CC_clk);
        rst = 1'b1;
        v = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h20, 8'h00, 1, 8'h00, 8'h77};
        run_vec(v, 1'b0, fe0, fe1);
        chk("latency_after_rst", fe1, ML + 1);

        // Inputs change after the latch edge: 0x42 must land at 0x40
        v = '{1, 0, 1, 0, 8'h40, 8'h42, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        run_vec(v, 1'b1, fe0, fe1);
        v = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h40, 8'h00, 1, 8'h00, 8'h42};
        run_vec(v, 1'b0, fe0, fe1);

        // Requester 0 holds its request; grants must alternate 0,1,0,1
        @(negedge CC_clk);
        wr0 = 1; ws0 = 8'h50; rs0 = 8'hAF; wd0 = 8'h60;
        wr1 = 0; rs1 = 8'h3C; ws1 = 8'hC3; wd1 = 8'h00;
        ba0 = 1; ba1 = 1;
        q.push_back('{1'b0, 1'b1, 8'h50});
        q.push_back('{1'b1, 1'b0, 8'hA5});
        q.push_back('{1'b0, 1'b1, 8'h50});
        q.push_back('{1'b1, 1'b0, 8'hA5});
        nfin = 0; cyc = 0;
        while (nfin < 4 && cyc < 100) begin
            @(negedge CC_clk);
            cyc++;
            if (fin0 || fin1) begin
                nfin++;
                if (nfin == 4) begin ba0 = 0; ba1 = 0; end
            end
        end
        if (nfin < 4) chk("hold_timeout", nfin, 4);
        ba0 = 0; ba1 = 0;
        repeat (4) @(negedge CC_clk);
        chk("idle_busy", busy, 0);
        chk("sb_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_snoop_bus_arbiter
`default_nettype wire
